// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster H/V counters, sync pulses, display enable, coordinates, strobes.
// Optional VGA_TIMING_RUNTIME_EN: timing taken from cfg_* ports, latched once per frame.
module vga_timing_gen #(
    parameter int CNT_W     = 12,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef VGA_TIMING_RUNTIME_EN
    input  logic [CNT_W-1:0] cfg_h_visible,
    input  logic [CNT_W-1:0] cfg_h_front,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_back,
    input  logic [CNT_W-1:0] cfg_v_visible,
    input  logic [CNT_W-1:0] cfg_v_front,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_back,
`endif
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] xpos,
    output logic [CNT_W-1:0] ypos,
    output logic             line_start,
    output logic             frame_start
);

    localparam int TW      = CNT_W + 1;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    logic [CNT_W-1:0] hcnt, vcnt;
    logic [TW-1:0]    h_vis, hs_beg, hs_end, h_tot;
    logic [TW-1:0]    v_vis, vs_beg, vs_end, v_tot;
    logic [TW-1:0]    hc_x, vc_x;
    logic             h_last, v_last;
    logic             h_in, v_in, h_act, v_act;

`ifdef VGA_TIMING_RUNTIME_EN
    logic [CNT_W-1:0] t_h_vis, t_h_fp, t_h_sy, t_h_bp;
    logic [CNT_W-1:0] t_v_vis, t_v_fp, t_v_sy, t_v_bp;

    // Latch runtime timing during reset and on the last pixel of a frame
    always_ff @(posedge clk) begin
        if (rst || (en && h_last && v_last)) begin
            t_h_vis <= cfg_h_visible;
            t_h_fp  <= cfg_h_front;
            t_h_sy  <= cfg_h_sync;
            t_h_bp  <= cfg_h_back;
            t_v_vis <= cfg_v_visible;
            t_v_fp  <= cfg_v_front;
            t_v_sy  <= cfg_v_sync;
            t_v_bp  <= cfg_v_back;
        end
    end

    // Region boundaries from the latched timing, one bit wider than counters
    always_comb begin
        h_vis  = TW'(t_h_vis);
        hs_beg = h_vis + TW'(t_h_fp);
        hs_end = hs_beg + TW'(t_h_sy);
        h_tot  = hs_end + TW'(t_h_bp);
        v_vis  = TW'(t_v_vis);
        vs_beg = v_vis + TW'(t_v_fp);
        vs_end = vs_beg + TW'(t_v_sy);
        v_tot  = vs_end + TW'(t_v_bp);
    end
`else
    assign h_vis  = TW'(H_VISIBLE);
    assign hs_beg = TW'(H_VISIBLE + H_FRONT);
    assign hs_end = TW'(H_VISIBLE + H_FRONT + H_SYNC);
    assign h_tot  = TW'(H_TOTAL);
    assign v_vis  = TW'(V_VISIBLE);
    assign vs_beg = TW'(V_VISIBLE + V_FRONT);
    assign vs_end = TW'(V_VISIBLE + V_FRONT + V_SYNC);
    assign v_tot  = TW'(V_TOTAL);
`endif

    assign hc_x   = {1'b0, hcnt};
    assign vc_x   = {1'b0, vcnt};
    assign h_last = (hc_x == h_tot - TW'(1));
    assign v_last = (vc_x == v_tot - TW'(1));
    assign h_in   = (hc_x < h_vis);
    assign v_in   = (vc_x < v_vis);
    assign h_act  = (hc_x >= hs_beg) && (hc_x < hs_end);
    assign v_act  = (vc_x >= vs_beg) && (vc_x < vs_end);

    // Flag parameter sets whose raster does not fit the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (H_TOTAL <= 2**CNT_W && V_TOTAL <= 2**CNT_W)
            else $error("vga_timing_gen: raster total exceeds counter range");
        end
    end

    // Advance the raster position one pixel per enabled clock
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (en) begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Register outputs decoded from the position before it advances
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            xpos        <= '0;
            ypos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                hsync       <= h_act ? HS_POL : ~HS_POL;
                vsync       <= v_act ? VS_POL : ~VS_POL;
                de          <= h_in && v_in;
                xpos        <= h_in ? hcnt : '0;
                ypos        <= v_in ? vcnt : '0;
                line_start  <= (hcnt == '0);
                frame_start <= (hcnt == '0) && (vcnt == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default 640x480 timing and a tiny
// active-high-sync raster, including enable stalls and mid-frame reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    logic        hs, vs, de, ls, fs;
    logic [11:0] x, y;
    logic        s_hs, s_vs, s_de, s_ls, s_fs;
    logic [3:0]  s_x, s_y;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
`ifdef VGA_TIMING_RUNTIME_EN
        .cfg_h_visible(12'd640),
        .cfg_h_front (12'd16),
        .cfg_h_sync  (12'd96),
        .cfg_h_back  (12'd48),
        .cfg_v_visible(12'd480),
        .cfg_v_front (12'd10),
        .cfg_v_sync  (12'd2),
        .cfg_v_back  (12'd33),
`endif
        .hsync       (hs),
        .vsync       (vs),
        .de          (de),
        .xpos        (x),
        .ypos        (y),
        .line_start  (ls),
        .frame_start (fs)
    );

    vga_timing_gen #(
        .CNT_W(4),
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_small (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
`ifdef VGA_TIMING_RUNTIME_EN
        .cfg_h_visible(4'd4),
        .cfg_h_front (4'd1),
        .cfg_h_sync  (4'd2),
        .cfg_h_back  (4'd1),
        .cfg_v_visible(4'd3),
        .cfg_v_front (4'd1),
        .cfg_v_sync  (4'd1),
        .cfg_v_back  (4'd1),
`endif
        .hsync       (s_hs),
        .vsync       (s_vs),
        .de          (s_de),
        .xpos        (s_x),
        .ypos        (s_y),
        .line_start  (s_ls),
        .frame_start (s_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        en = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold();
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_de", de, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_ls", ls, 0);
        chk("rst_fs", fs, 0);
        chk("rst_s_hs", s_hs, 0);
        chk("rst_s_vs", s_vs, 0);
        chk("rst_s_de", s_de, 0);

        rst = 1'b0;
        adv(1);
        chk("p0_de", de, 1);
        chk("p0_x", x, 0);
        chk("p0_y", y, 0);
        chk("p0_ls", ls, 1);
        chk("p0_fs", fs, 1);
        chk("p0_hs", hs, 1);
        chk("p0_vs", vs, 1);
        chk("p0_s_fs", s_fs, 1);
        chk("p0_s_hs", s_hs, 0);
        chk("p0_s_vs", s_vs, 0);

        adv(1);
        chk("p1_x", x, 1);
        chk("p1_ls", ls, 0);
        chk("p1_fs", fs, 0);
        chk("p1_s_x", s_x, 1);

        adv(4);
        chk("p5_x", x, 5);
        chk("p5_s_hs", s_hs, 1);
        chk("p5_s_de", s_de, 0);
        chk("p5_s_x", s_x, 0);
        adv(1);
        chk("p6_s_hs", s_hs, 1);
        adv(1);
        chk("p7_s_hs", s_hs, 0);
        adv(1);
        chk("p8_s_ls", s_ls, 1);
        chk("p8_s_fs", s_fs, 0);
        chk("p8_s_y", s_y, 1);
        chk("p8_s_de", s_de, 1);

        adv(24);
        chk("p32_s_vs", s_vs, 1);
        chk("p32_s_de", s_de, 0);
        chk("p32_s_y", s_y, 0);
        chk("p32_s_ls", s_ls, 1);
        adv(7);
        chk("p39_s_vs", s_vs, 1);
        adv(1);
        chk("p40_s_vs", s_vs, 0);
        adv(8);
        chk("p48_s_fs", s_fs, 1);
        chk("p48_s_de", s_de, 1);
        chk("p48_x", x, 48);

        adv(591);
        chk("p639_de", de, 1);
        chk("p639_x", x, 639);
        adv(1);
        chk("p640_de", de, 0);
        chk("p640_x", x, 0);
        chk("p640_hs", hs, 1);
        adv(15);
        chk("p655_hs", hs, 1);
        adv(1);
        chk("p656_hs", hs, 0);
        adv(95);
        chk("p751_hs", hs, 0);
        adv(1);
        chk("p752_hs", hs, 1);
        adv(47);
        chk("p799_ls", ls, 0);
        chk("p799_de", de, 0);
        adv(1);
        chk("p800_ls", ls, 1);
        chk("p800_fs", fs, 0);
        chk("p800_x", x, 0);
        chk("p800_y", y, 1);
        chk("p800_de", de, 1);

        hold();
        chk("h0_ls", ls, 0);
        chk("h0_x", x, 0);
        chk("h0_y", y, 1);
        chk("h0_de", de, 1);
        chk("h0_s_ls", s_ls, 0);
        chk("h0_s_vs", s_vs, 1);
        adv(1);
        chk("p801_x", x, 1);
        hold();
        chk("h1_x", x, 1);
        hold();
        chk("h2_x", x, 1);
        adv(1);
        chk("p802_x", x, 2);

        adv(1098);
        chk("p1900_x", x, 300);
        chk("p1900_y", y, 2);
        chk("p1900_de", de, 1);

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_de", de, 0);
        chk("mrst_x", x, 0);
        chk("mrst_y", y, 0);
        chk("mrst_hs", hs, 1);
        chk("mrst_vs", vs, 1);
        chk("mrst_ls", ls, 0);
        chk("mrst_fs", fs, 0);

        rst = 1'b0;
        adv(1);
        chk("rel_de", de, 1);
        chk("rel_x", x, 0);
        chk("rel_y", y, 0);
        chk("rel_ls", ls, 1);
        chk("rel_fs", fs, 1);
        chk("rel_s_fs", s_fs, 1);
        adv(1);
        chk("rel1_fs", fs, 0);
        chk("rel1_x", x, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
